// File: rtl/fetch_stage_param_if.sv
// fetch_stage_param_if: program-load, redirect and fetch-result signals of the fetch stage
interface fetch_stage_param_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8
);
   logic              Pipeline_Enable;
   logic              ProgMode;
   logic              Prog_Write;
   logic [ADDR_W-1:0] Addr_Prog;
   logic [DATA_W-1:0] Data_Prog;
   logic              Branch_Taken;
   logic [ADDR_W-1:0] Branch_Target;
   logic              Flush;
   logic [DATA_W-1:0] Instruction;
   logic [ADDR_W-1:0] PC_Out;
   logic [ADDR_W-1:0] PC_Next;
   logic              Valid;
   logic [ADDR_W:0]   Prog_Len;
   logic              Done;
   modport master (
      output Pipeline_Enable, ProgMode, Prog_Write, Addr_Prog, Data_Prog,
             Branch_Taken, Branch_Target, Flush,
      input  Instruction, PC_Out, PC_Next, Valid, Prog_Len, Done
   );
   modport slave (
      input  Pipeline_Enable, ProgMode, Prog_Write, Addr_Prog, Data_Prog,
             Branch_Taken, Branch_Target, Flush,
      output Instruction, PC_Out, PC_Next, Valid, Prog_Len, Done
   );
endinterface

// File: rtl/fetch_stage_param.sv
// fetch_stage_param: instruction memory with program-load port and run-mode fetch stage
module fetch_stage_param #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 8,
   parameter int RESET_PC = 0
) (
   input logic                clk,
   input logic                reset,
   fetch_stage_param_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] pc_q, pc_d, pc_out_q, pc_out_d, fetch_addr;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic              valid_q, valid_d, done_q, done_d;
   logic [ADDR_W:0]   len_q, len_d, wr_end, fetch_end;
   assign fetch_addr  = bus.Branch_Taken ? bus.Branch_Target : pc_q;
   assign wr_end      = {1'b0, bus.Addr_Prog} + (ADDR_W+1)'(1);
   assign fetch_end   = {1'b0, fetch_addr} + (ADDR_W+1)'(1);
   assign bus.Instruction = instr_q;
   assign bus.PC_Out      = pc_out_q;
   assign bus.PC_Next     = pc_out_q + ADDR_W'(1);
   assign bus.Valid       = valid_q;
   assign bus.Prog_Len    = len_q;
   assign bus.Done        = done_q;
   // program writes land only in program mode; contents survive reset
   always_ff @(posedge clk)
      if (reset && !bus.ProgMode && bus.Prog_Write)
         mem[bus.Addr_Prog] <= bus.Data_Prog;
   // next-state: program mode restarts fetch, run mode fetches/bubbles/halts when enabled
   always_comb begin
      pc_d     = pc_q;
      pc_out_d = pc_out_q;
      instr_d  = instr_q;
      valid_d  = valid_q;
      done_d   = done_q;
      len_d    = len_q;
      if (!bus.ProgMode) begin
         pc_d    = PC_INIT;
         instr_d = '0;
         valid_d = 1'b0;
         done_d  = 1'b0;
         len_d   = (bus.Prog_Write && wr_end > len_q) ? wr_end : len_q;
      end else if (bus.Pipeline_Enable) begin
         if (done_q) begin
            instr_d = '0;
            valid_d = 1'b0;
         end else if (bus.Flush) begin
            instr_d = '0;
            valid_d = 1'b0;
            pc_d    = fetch_addr;
         end else if (len_q == '0) begin
            instr_d = '0;
            valid_d = 1'b0;
            done_d  = 1'b1;
         end else begin
            instr_d  = mem[fetch_addr];
            pc_out_d = fetch_addr;
            valid_d  = 1'b1;
            pc_d     = fetch_addr + ADDR_W'(1);
            done_d   = fetch_end >= len_q;
         end
      end
   end
   // state registers with synchronous active-low reset
   always_ff @(posedge clk)
      if (!reset) begin
         pc_q     <= PC_INIT;
         pc_out_q <= '0;
         instr_q  <= '0;
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
         len_q    <= '0;
      end else begin
         pc_q     <= pc_d;
         pc_out_q <= pc_out_d;
         instr_q  <= instr_d;
         valid_q  <= valid_d;
         done_q   <= done_d;
         len_q    <= len_d;
      end
endmodule

// File: tb/tb_fetch_stage_param.sv
// tb_fetch_stage_param: directed plan plus random run/program traffic against a behavioural model
module tb_fetch_stage_param;
   localparam int DW = 32;
   localparam int AW = 8;
   localparam int DEPTH = 256;
   localparam int RST_PC = 0;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int checks = 0;
   int failures = 0;
   bit [31:0] m_mem [DEPTH];
   bit [31:0] m_instr;
   int m_pc, m_pcout, m_len;
   bit m_valid, m_done;
   int vals [4] = '{8, 64, 12, 18};
   fetch_stage_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
   fetch_stage_param #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(RST_PC)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   always #5 clk = ~clk;
   // compare one observed value with the expected one
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   // behavioural model of one rising edge using the currently driven inputs
   task automatic model();
      int f, a;
      if (!reset) begin
         m_pc = RST_PC; m_instr = 0; m_pcout = 0; m_valid = 0; m_done = 0; m_len = 0;
      end else if (!bus.ProgMode) begin
         a = int'(bus.Addr_Prog);
         if (bus.Prog_Write) begin
            m_mem[a] = bus.Data_Prog;
            if (a + 1 > m_len) m_len = a + 1;
         end
         m_pc = RST_PC; m_instr = 0; m_valid = 0; m_done = 0;
      end else if (bus.Pipeline_Enable && m_done) begin
         m_instr = 0; m_valid = 0;
      end else if (bus.Pipeline_Enable) begin
         f = bus.Branch_Taken ? int'(bus.Branch_Target) : m_pc;
         if (bus.Flush) begin
            m_instr = 0; m_valid = 0; m_pc = f;
         end else if (m_len == 0) begin
            m_instr = 0; m_valid = 0; m_done = 1;
         end else begin
            m_instr = m_mem[f]; m_pcout = f; m_valid = 1;
            m_pc = (f + 1) % DEPTH;
            m_done = (f >= m_len - 1);
         end
      end
   endtask
   // one clock: model the edge, then check every output
   task automatic cyc();
      @(posedge clk);
      model();
      #1;
      chk("instr", bus.Instruction, m_instr);
      chk("pc_out", bus.PC_Out, m_pcout);
      chk("pc_next", bus.PC_Next, (m_pcout + 1) % DEPTH);
      chk("valid", bus.Valid, m_valid);
      chk("prog_len", bus.Prog_Len, m_len);
      chk("done", bus.Done, m_done);
   endtask
   task automatic step(input bit rn, pm, en, wr, input int a, d, input bit br, input int bt, input bit fl);
      reset = rn;
      bus.ProgMode = pm;
      bus.Pipeline_Enable = en;
      bus.Prog_Write = wr;
      bus.Addr_Prog = AW'(a);
      bus.Data_Prog = DW'(d);
      bus.Branch_Taken = br;
      bus.Branch_Target = AW'(bt);
      bus.Flush = fl;
      cyc();
   endtask
   initial begin
      bit pm;
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_instr", bus.Instruction, 0);
      chk("rst_valid", bus.Valid, 0);
      chk("rst_len", bus.Prog_Len, 0);
      for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 1, i, int'($urandom), 0, 0, 0);
      chk("fill_len", bus.Prog_Len, 256);
      step(1, 1, 1, 0, 0, 0, 1, 254, 0);
      step(1, 1, 1, 0, 0, 0, 0, 0, 0);
      chk("top_pc", bus.PC_Out, 255);
      chk("top_done", bus.Done, 1);
      step(1, 1, 1, 0, 0, 0, 0, 0, 0);
      chk("top_nowrap", bus.Valid, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(1, 0, 1, 1, i, vals[i], 0, 0, 0);
      chk("t1_len", bus.Prog_Len, 4);
      chk("t1_valid", bus.Valid, 0);
      for (int i = 0; i < 4; i++) begin
         step(1, 1, 1, 0, 0, 0, 0, 0, 0);
         chk("t2_instr", bus.Instruction, vals[i]);
         chk("t2_pc", bus.PC_Out, i);
         chk("t2_next", bus.PC_Next, i + 1);
      end
      chk("t2_done", bus.Done, 1);
      step(1, 1, 1, 0, 0, 0, 0, 0, 0);
      chk("t2_after_valid", bus.Valid, 0);
      chk("t2_after_done", bus.Done, 1);
      step(1, 0, 1, 0, 0, 0, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         step(1, 1, 0, 0, 0, 0, 1, 3, 1);
         chk("t3_instr", bus.Instruction, 64);
         chk("t3_pc", bus.PC_Out, 1);
         chk("t3_valid", bus.Valid, 1);
      end
      step(1, 1, 1, 0, 0, 0, 0, 0, 0);
      chk("t3_resume", bus.Instruction, 12);
      step(1, 0, 1, 0, 0, 0, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0, 0, 0, 0);
      step(1, 1, 1, 1, 1, 999, 1, 0, 0);
      chk("t4_br_instr", bus.Instruction, 8);
      chk("t4_br_pc", bus.PC_Out, 0);
      step(1, 1, 1, 0, 0, 0, 0, 0, 0);
      chk("t4_nowrite", bus.Instruction, 64);
      step(1, 1, 1, 0, 0, 0, 1, 3, 1);
      chk("t5_bubble_valid", bus.Valid, 0);
      chk("t5_bubble_instr", bus.Instruction, 0);
      step(1, 1, 1, 0, 0, 0, 0, 0, 0);
      chk("t5_instr", bus.Instruction, 18);
      chk("t5_pc", bus.PC_Out, 3);
      chk("t5_done", bus.Done, 1);
      step(0, 1, 1, 0, 0, 0, 0, 0, 0);
      chk("t6_rst_done", bus.Done, 0);
      chk("t6_rst_pc", bus.PC_Out, 0);
      step(1, 1, 1, 0, 0, 0, 0, 0, 0);
      chk("t6_empty_done", bus.Done, 1);
      chk("t6_empty_valid", bus.Valid, 0);
      step(1, 0, 0, 1, 0, 77, 0, 0, 0);
      chk("t6_len", bus.Prog_Len, 1);
      step(1, 1, 1, 0, 0, 0, 1, 1, 0);
      chk("t6_beyond", bus.Instruction, 64);
      chk("t6_beyond_done", bus.Done, 1);
      pm = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) pm = ~pm;
         step($urandom_range(0, 59) != 0, pm, $urandom_range(0, 4) != 0,
              1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom),
              $urandom_range(0, 5) == 0, int'($urandom_range(0, 31)), $urandom_range(0, 7) == 0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fetch_stage_param.md
Name: fetch_stage_param

Overview:
Parametrised instruction-fetch stage (pipeline stage 1) for the 5-stage MIPS core.
- Holds an on-chip instruction memory loaded through a program-mode port.
- In run mode it fetches one word per enabled cycle, with stall, branch redirect and flush/bubble insertion.
- Tracks the loaded program length and flags end-of-program so downstream stages receive no garbage fetches.

Parameters:
DATA_W, 32, instruction word width
ADDR_W, 8, word-address width; memory depth 2^ADDR_W
RESET_PC, 0, fetch start address after reset or on return to program mode (must be < 2^ADDR_W)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset
Pipeline_Enable  in  1  1 = stage advances; 0 = stall, all registers hold
ProgMode  in  1  0 = program (write), 1 = run (fetch)
Prog_Write  in  1  write strobe, honoured only in program mode
Addr_Prog  in  ADDR_W  program write address
Data_Prog  in  DATA_W  program write data
Branch_Taken  in  1  redirect request from later stage
Branch_Target  in  ADDR_W  redirect word address
Flush  in  1  insert bubble on this fetch
Instruction  out  DATA_W  registered fetched word
PC_Out  out  ADDR_W  address of Instruction
PC_Next  out  ADDR_W  PC_Out+1, combinational, wraps mod 2^ADDR_W
Valid  out  1  Instruction is a real fetch
Prog_Len  out  ADDR_W+1  highest written address + 1
Done  out  1  last program word has been fetched (sticky)

Behaviour:
- Memory: 2^ADDR_W x DATA_W, synchronous write, registered read. Contents are never cleared by reset.
- Reset (reset==0 at edge) overrides everything:
  - Internal PC=RESET_PC.
  - Instruction=0, PC_Out=0, Valid=0, Done=0, Prog_Len=0.
- Program mode (ProgMode=0):
  - Prog_Write=1 writes mem[Addr_Prog]<=Data_Prog.
  - Prog_Len<=max(Prog_Len, Addr_Prog+1), computed at ADDR_W+1 bits.
  - PC<=RESET_PC; Instruction=0, Valid=0, Done=0.
  - Pipeline_Enable, Branch_Taken and Flush are ignored.
- Run mode (ProgMode=1) ignores Prog_Write. Per-edge priority when Pipeline_Enable=1 and Done=0, with fetch address F = Branch_Taken ? Branch_Target : PC:
  - Flush=1: Instruction<=0, Valid<=0. PC<=Branch_Taken ? Branch_Target : PC (target not consumed; fetched next cycle).
  - Else: Instruction<=mem[F], PC_Out<=F, Valid<=1, PC<=F+1 (wraps).
    - If F >= Prog_Len-1 (or Prog_Len==0), Done<=1.
    - With Prog_Len==0, no fetch occurs: Valid<=0, Instruction<=0, Done<=1.
- Run, Done=1 and enabled: Instruction<=0, Valid<=0, PC holds; Branch_Taken is ignored.
- Pipeline_Enable=0: every register holds, including Valid and Done. Branch_Taken and Flush are dropped; the hazard logic must hold them until enable.
- Latency: one edge from fetch address to Instruction. Zero-penalty redirect as seen from this stage.
- ProgMode 1->0 mid-run: next edge applies program-mode values. Prog_Len is retained, so further writes append. A later switch back to run restarts at RESET_PC.
- Branch_Target >= Prog_Len: the word is fetched and Done is set.
- Fetch at address 2^ADDR_W-1 with a full memory sets Done, so no wrap fetch occurs.

Test Plan:
1. Reset low 1 cycle, then ProgMode=0 with Prog_Write writing 8,64,12,18 to addresses 0..3 -> Prog_Len=4, Valid=0, Instruction=0 throughout.
2. ProgMode=1, enable high -> Instruction 8,64,12,18 on consecutive edges with PC_Out 0..3 and PC_Next 1..4. Done=1 with 18. The next edge gives Valid=0, Instruction=0, and Done stays 1.
3. After Instruction=64 drop Pipeline_Enable for 2 cycles -> Instruction=64, PC_Out=1, Valid=1 held for both cycles. Re-enable -> 12.
4. With Instruction=64 pulse Branch_Taken, Branch_Target=0 -> next Instruction=8, PC_Out=0, then 64. Prog_Write pulsed during run leaves memory unchanged.
5. Flush=1 with Branch_Taken=1, target=3 -> one bubble (Valid=0, Instruction=0), then Instruction=18, PC_Out=3, Done=1.
6. Reset low mid-run, then ProgMode=1 -> all outputs 0 after reset. First run edge gives Done=1, Valid=0 (Prog_Len=0). Reprogramming address 0 only gives Prog_Len=1, and the memory still returns 64 at address 1 if branched to.
